// File: rtl/sim_ram_arbiter.sv
// Two-host arbiter in front of a single-port RAM with one-cycle read latency.
// Define SIM_RAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to host 0.
module sim_ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            h0_req_i,
  output logic            h0_gnt_o,
  input  logic            h0_we_i,
  input  logic [AW-1:0]   h0_addr_i,
  input  logic [DW-1:0]   h0_wdata_i,
  input  logic [DW/8-1:0] h0_be_i,
  output logic            h0_rvalid_o,
  output logic [DW-1:0]   h0_rdata_o,
  input  logic            h1_req_i,
  output logic            h1_gnt_o,
  input  logic            h1_we_i,
  input  logic [AW-1:0]   h1_addr_i,
  input  logic [DW-1:0]   h1_wdata_i,
  input  logic [DW/8-1:0] h1_be_i,
  output logic            h1_rvalid_o,
  output logic [DW-1:0]   h1_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wmask_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  logic gnt0, gnt1;
  logic rsp_vld, rsp_owner, rsp_write;

`ifdef SIM_RAM_ARB_ROUND_ROBIN_EN
  // last_gnt=1 means host 1 won most recently, so host 0 wins the next tie
  logic last_gnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (h0_req_i && h1_req_i) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = h0_req_i;
        gnt1 = h1_req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)              last_gnt <= 1'b1;
    else if (gnt0 || gnt1)  last_gnt <= gnt1;
  end
`else
  assign gnt0 = ~rst_i & h0_req_i;
  assign gnt1 = ~rst_i & h1_req_i & ~h0_req_i;
`endif

  assign h0_gnt_o = gnt0;
  assign h1_gnt_o = gnt1;

  // Command bus is idle (and write-safe) whenever nobody holds a grant
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (gnt0) begin
      mem_req_o   = 1'b1;
      mem_we_o    = h0_we_i;
      mem_addr_o  = h0_addr_i;
      mem_wdata_o = h0_wdata_i;
      mem_wmask_o = h0_be_i;
    end else if (gnt1) begin
      mem_req_o   = 1'b1;
      mem_we_o    = h1_we_i;
      mem_addr_o  = h1_addr_i;
      mem_wdata_o = h1_wdata_i;
      mem_wmask_o = h1_be_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld   <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_write <= 1'b0;
    end else begin
      rsp_vld <= gnt0 | gnt1;
      if (gnt0 || gnt1) begin
        rsp_owner <= gnt1;
        rsp_write <= gnt1 ? h1_we_i : h0_we_i;
      end
    end
  end

  // Gating with rst_i drops a response whose grant landed just before reset
  assign h0_rvalid_o = ~rst_i & rsp_vld & ~rsp_owner;
  assign h1_rvalid_o = ~rst_i & rsp_vld &  rsp_owner;
  assign h0_rdata_o  = (h0_rvalid_o && !rsp_write) ? mem_rdata_i : '0;
  assign h1_rdata_o  = (h1_rvalid_o && !rsp_write) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sim_ram_arbiter.sv
// Scoreboard bench for sim_ram_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them against the response ports.
module tb_sim_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        h0_req_i, h0_gnt_o, h0_we_i, h0_rvalid_o;
  logic [31:0] h0_addr_i, h0_wdata_i, h0_rdata_o;
  logic [3:0]  h0_be_i;
  logic        h1_req_i, h1_gnt_o, h1_we_i, h1_rvalid_o;
  logic [31:0] h1_addr_i, h1_wdata_i, h1_rdata_o;
  logic [3:0]  h1_be_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wmask_o;

  sim_ram_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .h0_req_i(h0_req_i), .h0_gnt_o(h0_gnt_o), .h0_we_i(h0_we_i), .h0_addr_i(h0_addr_i),
    .h0_wdata_i(h0_wdata_i), .h0_be_i(h0_be_i), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
    .h1_req_i(h1_req_i), .h1_gnt_o(h1_gnt_o), .h1_we_i(h1_we_i), .h1_addr_i(h1_addr_i),
    .h1_wdata_i(h1_wdata_i), .h1_be_i(h1_be_i), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM model: byte-masked write on we alone, registered read data
  logic [31:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) ram[mem_addr_o[7:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    mem_rdata_i <= ram[mem_addr_o[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0, ntotal = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int host; logic [31:0] data; int cyc; } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (!rst_i && (h0_rvalid_o || h1_rvalid_o)) begin
      chk("rvalid_onehot", 32'($countones({h1_rvalid_o, h0_rvalid_o})), 32'd1);
      if (q.size() == 0) begin
        chk("rsp_unexpected", {30'd0, h1_rvalid_o, h0_rvalid_o}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_host", h1_rvalid_o ? 32'd1 : 32'd0, 32'(e.host));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_data", e.host == 1 ? h1_rdata_o : h0_rdata_o, e.data);
      end
    end
  end

  task automatic set_host(input int host, input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    if (host == 0) begin
      h0_req_i = req; h0_we_i = we; h0_addr_i = addr; h0_wdata_i = wdata; h0_be_i = be;
    end else begin
      h1_req_i = req; h1_we_i = we; h1_addr_i = addr; h1_wdata_i = wdata; h1_be_i = be;
    end
  endtask

  // Entered at posedge+1; leaves at the following posedge+1 so calls chain back to back
  task automatic issue(input int host, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rd);
    exp_t e;
    set_host(host, 1'b1, we, addr, wdata, be);
    @(negedge clk);
    chk("gnt_single", {30'd0, h1_gnt_o, h0_gnt_o}, host == 1 ? 32'd2 : 32'd1);
    chk("mem_req", {31'd0, mem_req_o}, 32'd1);
    e.host = host; e.data = we ? 32'h0 : exp_rd; e.cyc = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    set_host(host, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o, mem_req_o, mem_we_o, mem_wmask_o}, 32'd0);
    chk({name, "_rdata"}, h0_rdata_o | h1_rdata_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_i = 1'b1;
    set_host(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_host(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // h0 write then read, first request in the first cycle out of reset
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // h1 full write, byte-1 clear, read back
    issue(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0);
    issue(1, 1'b1, 32'h20, 32'h00000000, 4'h2, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hFFFF00FF);

    // Idle cycles with write enable high but no request must not touch RAM
    set_host(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
    set_host(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("idle_cmd", {29'd0, mem_req_o, mem_we_o, |mem_wmask_o}, 32'd0);
      @(posedge clk); #1;
    end
    set_host(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // Consecutive reads from different hosts
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hFFFF00FF);
    repeat (2) @(posedge clk); #1;

    // Fresh reset, then both hosts read continuously for 8 cycles
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    set_host(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_host(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      int w;
`ifdef SIM_RAM_ARB_ROUND_ROBIN_EN
      w = i % 2;
`else
      w = 0;
`endif
      @(negedge clk);
      chk("contention_gnt", {30'd0, h1_gnt_o, h0_gnt_o}, w == 1 ? 32'd2 : 32'd1);
      e.host = w; e.data = (w == 1) ? 32'hFFFF00FF : 32'hDEADBEEF; e.cyc = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
    end
    set_host(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_host(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk); #1;

    // h0 read granted, reset the very next cycle: its response must vanish
    set_host(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("pre_reset_gnt", {30'd0, h1_gnt_o, h0_gnt_o}, 32'd1);
    @(posedge clk); #1;
    set_host(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_host(1, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    rst_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs("mid_reset_outputs");
      @(posedge clk); #1;
    end
    set_host(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/sim_ram_arbiter.md
SIM_RAM_ARBITER -- requirements
Module: sim_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port hN_req_i (N=0,1), input, 1, host N request, held until granted.
REQ-006 SHALL have port hN_gnt_o, output, 1, host N grant, combinational, same cycle as accept.
REQ-007 SHALL have port hN_we_i, input, 1, host N write enable.
REQ-008 SHALL have port hN_addr_i, input, AW, host N word address.
REQ-009 SHALL have port hN_wdata_i, input, DW, host N write data.
REQ-010 SHALL have port hN_be_i, input, DW/8, host N byte enables.
REQ-011 SHALL have port hN_rvalid_o, output, 1, host N response valid.
REQ-012 SHALL have port hN_rdata_o, output, DW, host N read data.
REQ-013 SHALL have ports mem_req_o/mem_we_o, output, 1 each, RAM request/write enable.
REQ-014 SHALL have ports mem_addr_o (AW), mem_wdata_o (DW), mem_wmask_o (DW/8), output, RAM command.
REQ-015 SHALL have port mem_rdata_i, input, DW, RAM read data, valid one cycle after a read request.

Function
REQ-016 SHALL grant at most one host per cycle; grant only to a host with hN_req_i=1.
REQ-017 SHALL, with exactly one host requesting, grant that host in the same cycle.
REQ-018 SHALL, with both requesting, resolve per REQ-033/REQ-034.
REQ-019 SHALL drive mem_req_o=1 and mux winner's we/addr/wdata/be onto mem_* in the grant cycle.
REQ-020 SHALL drive mem_req_o=0, mem_we_o=0, mem_wmask_o=0 in any cycle without a grant (RAM writes on we alone).
REQ-021 SHALL register response state {valid, owner, was_write} on every grant.
REQ-022 SHALL assert hN_rvalid_o for exactly one cycle, the cycle after host N's grant, for reads and writes.
REQ-023 SHALL drive hN_rdata_o=mem_rdata_i on read responses and 0 otherwise.
REQ-024 SHALL allow back-to-back grants: grant in cycle N+1 concurrent with response for cycle-N grant.
REQ-025 SHALL not assert hN_rvalid_o for the host not owning the response.
REQ-026 SHALL hold hN_gnt_o=0 for a requester losing arbitration; its command SHALL not reach RAM.

Reset
REQ-027 SHALL on rst_i=1 clear response valid, owner=0, was_write=0, last-grant pointer=1.
REQ-028 SHALL during rst_i=1 drive all hN_gnt_o=0, hN_rvalid_o=0, hN_rdata_o=0, mem_req_o=0, mem_we_o=0, mem_wmask_o=0.
REQ-029 SHALL drop a pending response when reset asserts mid-transaction; no rvalid after reset release for it.
REQ-030 SHALL accept requests the first cycle with rst_i=0.

Configuration
REQ-031 SHALL use macro SIM_RAM_ARB_ROUND_ROBIN_EN to select arbitration policy.
REQ-032 SHALL update the last-grant pointer on every grant when macro defined.
REQ-033 SHALL, with macro defined, on contention grant the host not granted last (pointer=1 -> host 0).
REQ-034 SHALL, without macro, on contention always grant host 0; pointer logic absent.

Verification
REQ-035 SHALL cover: h0 write addr 0x10 data 0xDEADBEEF be 0xF, then h0 read 0x10 -> gnt same cycle, rvalid next cycle each, rdata 0xDEADBEEF.
REQ-036 SHALL cover: h1 write 0x20 data 0xFFFFFFFF, then be 0x2 data 0x00000000, read -> rdata 0xFFFF00FF.
REQ-037 SHALL cover: both read continuously 8 cycles after reset -> with macro grants alternate 0,1,0,1...; without macro h0 all 8, h1 none.
REQ-038 SHALL cover: idle cycles with hN_we_i=1, req=0 -> mem_we_o=0, RAM contents unchanged.
REQ-039 SHALL cover: h0 read granted, rst_i=1 next cycle -> no h0_rvalid_o after release, outputs zero during reset.
REQ-040 SHALL cover: h0 read then h1 read in consecutive cycles -> h0_rvalid_o then h1_rvalid_o in consecutive cycles, correct rdata each, never both same cycle.
